// File: rtl/ex_stage_pkg.sv
// Shared constants for the RV32I execute stage: aluop codes, reset level, divider state codes.
package ex_stage_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 6;

  localparam logic RstEnable = 1'b0;

  localparam logic [1:0] DivIdle = 2'b00;
  localparam logic [1:0] DivBusy = 2'b01;
  localparam logic [1:0] DivDone = 2'b10;

  localparam logic [5:0] EXE_NOP_OP    = 6'd0;
  localparam logic [5:0] EXE_ADD_OP    = 6'd1;
  localparam logic [5:0] EXE_SUB_OP    = 6'd2;
  localparam logic [5:0] EXE_AND_OP    = 6'd3;
  localparam logic [5:0] EXE_OR_OP     = 6'd4;
  localparam logic [5:0] EXE_XOR_OP    = 6'd5;
  localparam logic [5:0] EXE_SLL_OP    = 6'd6;
  localparam logic [5:0] EXE_SRL_OP    = 6'd7;
  localparam logic [5:0] EXE_SRA_OP    = 6'd8;
  localparam logic [5:0] EXE_SLT_OP    = 6'd9;
  localparam logic [5:0] EXE_SLTU_OP   = 6'd10;
  localparam logic [5:0] EXE_LUI_OP    = 6'd11;
  localparam logic [5:0] EXE_AUIPC_OP  = 6'd12;
  localparam logic [5:0] EXE_JAL_OP    = 6'd13;
  localparam logic [5:0] EXE_JALR_OP   = 6'd14;
  localparam logic [5:0] EXE_MUL_OP    = 6'd15;
  localparam logic [5:0] EXE_MULH_OP   = 6'd16;
  localparam logic [5:0] EXE_MULHSU_OP = 6'd17;
  localparam logic [5:0] EXE_MULHU_OP  = 6'd18;
  localparam logic [5:0] EXE_DIV_OP    = 6'd19;
  localparam logic [5:0] EXE_DIVU_OP   = 6'd20;
  localparam logic [5:0] EXE_REM_OP    = 6'd21;
  localparam logic [5:0] EXE_REMU_OP   = 6'd22;

  function automatic logic is_div_op(input logic [5:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) ||
           (op == EXE_REM_OP) || (op == EXE_REMU_OP);
  endfunction

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Present only when RV32M_EN is defined.
`ifdef RV32M_EN
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        signed_op,
  input  logic        rem_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] result,
  output logic        ready
);

  localparam int CntW = $clog2(DIV_CYCLES);
  localparam logic [CntW-1:0] LastIter = CntW'(DIV_CYCLES - 1);

  logic [1:0]      state;
  logic [CntW-1:0] cnt;
  logic [31:0]     quot;
  logic [31:0]     rem;
  logic [31:0]     divs;
  logic            quot_neg;
  logic            rem_neg;
  logic            rem_sel;

  logic            a_neg;
  logic            b_neg;
  logic [31:0]     abs_a;
  logic [31:0]     abs_b;
  logic            overflow;
  logic [32:0]     rem_shift;
  logic [32:0]     trial;

  assign a_neg    = signed_op & dividend[31];
  assign b_neg    = signed_op & divisor[31];
  assign abs_a    = neg_if(dividend, a_neg);
  assign abs_b    = neg_if(divisor, b_neg);
  assign overflow = signed_op && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);

  // A borrow out of the trial subtraction means the shifted remainder is below the divisor.
  assign rem_shift = {rem, quot[31]};
  assign trial     = rem_shift - {1'b0, divs};

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= DivIdle;
      cnt      <= '0;
      quot     <= '0;
      rem      <= '0;
      divs     <= '0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
      rem_sel  <= 1'b0;
    end else begin
      case (state)
        DivIdle: begin
          if (start) begin
            rem_sel <= rem_op;
            if (divisor == 32'd0) begin
              quot     <= 32'hFFFF_FFFF;
              rem      <= dividend;
              quot_neg <= 1'b0;
              rem_neg  <= 1'b0;
              state    <= DivDone;
            end else if (overflow) begin
              quot     <= 32'h8000_0000;
              rem      <= 32'd0;
              quot_neg <= 1'b0;
              rem_neg  <= 1'b0;
              state    <= DivDone;
            end else begin
              quot     <= abs_a;
              rem      <= 32'd0;
              divs     <= abs_b;
              quot_neg <= a_neg ^ b_neg;
              rem_neg  <= a_neg;
              cnt      <= '0;
              state    <= DivBusy;
            end
          end
        end
        DivBusy: begin
          if (abort) begin
            state <= DivIdle;
          end else begin
            quot <= {quot[30:0], ~trial[32]};
            rem  <= trial[32] ? rem_shift[31:0] : trial[31:0];
            cnt  <= cnt + 1'b1;
            if (cnt == LastIter) state <= DivDone;
          end
        end
        DivDone: state <= DivIdle;
        default: state <= DivIdle;
      endcase
    end
  end

  assign ready  = (state == DivDone);
  assign result = rem_sel ? neg_if(rem, rem_neg) : neg_if(quot, quot_neg);

endmodule
`endif

// File: rtl/ex_stage.sv
// RV32I execute stage: single-cycle ALU mux plus stall control for the iterative divider.
// RV32M_EN compiles in MUL/MULH* and the DIV/REM divider; without it those ops decode as unknown.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] pc_store_i,
  input  logic        ignore_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  logic signed [31:0] reg1_s;
  logic signed [31:0] reg2_s;
  logic [4:0]         shamt;
  logic [31:0]        alu;
  logic               alu_valid;
  logic               run;

  assign reg1_s = reg1_i;
  assign reg2_s = reg2_i;
  assign shamt  = reg2_i[4:0];
  assign run    = (rst != RstEnable) && !ignore_i;

`ifdef RV32M_EN
  logic signed [32:0] mul_a;
  logic signed [32:0] mul_b;
  logic signed [63:0] product;
  logic [31:0]        div_result;
  logic               div_ready;

  // A 33-bit signed multiply covers all four flavours; the extra bit carries the sign or a zero.
  assign mul_a   = {((aluop_i == EXE_MULH_OP) || (aluop_i == EXE_MULHSU_OP)) & reg1_i[31], reg1_i};
  assign mul_b   = {(aluop_i == EXE_MULH_OP) & reg2_i[31], reg2_i};
  assign product = 64'(mul_a) * 64'(mul_b);

  div_unit #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (run && is_div_op(aluop_i)),
    .abort    (ignore_i),
    .signed_op((aluop_i == EXE_DIV_OP) || (aluop_i == EXE_REM_OP)),
    .rem_op   ((aluop_i == EXE_REM_OP) || (aluop_i == EXE_REMU_OP)),
    .dividend (reg1_i),
    .divisor  (reg2_i),
    .result   (div_result),
    .ready    (div_ready)
  );

  assign stallreq_o = run && is_div_op(aluop_i) && !div_ready;
`else
  logic unused_ok;
  assign unused_ok  = &{1'b0, clk};
  assign stallreq_o = 1'b0;
`endif

  always_comb begin
    alu       = '0;
    alu_valid = 1'b1;
    case (aluop_i)
      EXE_ADD_OP:   alu = reg1_i + reg2_i;
      EXE_SUB_OP:   alu = reg1_i - reg2_i;
      EXE_AND_OP:   alu = reg1_i & reg2_i;
      EXE_OR_OP:    alu = reg1_i | reg2_i;
      EXE_XOR_OP:   alu = reg1_i ^ reg2_i;
      EXE_SLL_OP:   alu = reg1_i << shamt;
      EXE_SRL_OP:   alu = reg1_i >> shamt;
      EXE_SRA_OP:   alu = 32'(reg1_s >>> shamt);
      EXE_SLT_OP:   alu = {31'd0, reg1_s < reg2_s};
      EXE_SLTU_OP:  alu = {31'd0, reg1_i < reg2_i};
      EXE_LUI_OP:   alu = reg2_i;
      EXE_AUIPC_OP: alu = reg1_i + reg2_i;
      EXE_JAL_OP,
      EXE_JALR_OP:  alu = pc_store_i;
`ifdef RV32M_EN
      EXE_MUL_OP:   alu = product[31:0];
      EXE_MULH_OP,
      EXE_MULHSU_OP,
      EXE_MULHU_OP: alu = product[63:32];
      EXE_DIV_OP,
      EXE_DIVU_OP,
      EXE_REM_OP,
      EXE_REMU_OP:  alu = div_ready ? div_result : 32'd0;
`endif
      default:      alu_valid = 1'b0;
    endcase
  end

  assign wd_o    = (rst != RstEnable) ? wd_i : '0;
  assign wreg_o  = run && wreg_i && alu_valid;
  assign wdata_o = run ? alu : 32'd0;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU vectors, multiply, divide timing/special cases, abort and reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

`ifdef RV32M_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  aluop;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic [31:0] pc_store;
  logic        ignore;
  logic [4:0]  wd_out;
  logic        wreg_out;
  logic [31:0] wdata_out;
  logic        stallreq;

  int vectors     = 0;
  int miscompares = 0;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .aluop_i   (aluop),
    .reg1_i    (reg1),
    .reg2_i    (reg2),
    .wd_i      (wd),
    .wreg_i    (wreg),
    .pc_store_i(pc_store),
    .ignore_i  (ignore),
    .wd_o      (wd_out),
    .wreg_o    (wreg_out),
    .wdata_o   (wdata_out),
    .stallreq_o(stallreq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic alu_vec(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic exp_wreg);
    aluop = op; reg1 = a; reg2 = b; wd = 5'd3; wreg = 1'b1; ignore = 1'b0;
    #1;
    check_val({tag, "_data"}, wdata_out, exp);
    check_val({tag, "_wreg"}, {31'd0, wreg_out}, {31'd0, exp_wreg});
  endtask

  task automatic run_div(input string tag, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall, input logic [31:0] exp);
    int n;
    n = 0;
    @(posedge clk); #1;
    aluop = op; reg1 = a; reg2 = b; wd = 5'd7; wreg = 1'b1; ignore = 1'b0;
    #1;
    while (stallreq && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check_val({tag, "_stall"}, 32'(n), 32'(exp_stall));
    check_val({tag, "_data"}, wdata_out, exp);
    check_val({tag, "_wreg"}, {31'd0, wreg_out}, {31'd0, MEN});
    aluop = EXE_NOP_OP;
  endtask

  initial begin
    rst = 1'b0; aluop = EXE_ADD_OP; reg1 = 32'd5; reg2 = 32'd2; wd = 5'd3;
    wreg = 1'b1; pc_store = 32'h44; ignore = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_data", wdata_out, 32'd0);
    check_val("rst_wreg", {31'd0, wreg_out}, 32'd0);
    check_val("rst_wd", {27'd0, wd_out}, 32'd0);
    check_val("rst_stall", {31'd0, stallreq}, 32'd0);
    aluop = EXE_DIV_OP; #1;
    check_val("rst_div_stall", {31'd0, stallreq}, 32'd0);
    aluop = EXE_NOP_OP; #1;
    rst = 1'b1;

    // Single-cycle ALU vectors
    alu_vec("add", EXE_ADD_OP, 32'd5, 32'hFFFF_FFFD, 32'd2, 1'b1);
    check_val("add_wd", {27'd0, wd_out}, 32'd3);
    check_val("add_stall", {31'd0, stallreq}, 32'd0);
    alu_vec("sub", EXE_SUB_OP, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1);
    alu_vec("xor", EXE_XOR_OP, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 1'b1);
    alu_vec("sll", EXE_SLL_OP, 32'd1, 32'h24, 32'h10, 1'b1);
    alu_vec("sra", EXE_SRA_OP, 32'h8000_0000, 32'h21, 32'hC000_0000, 1'b1);
    alu_vec("srl", EXE_SRL_OP, 32'h8000_0000, 32'h1F, 32'h1, 1'b1);
    alu_vec("slt", EXE_SLT_OP, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1);
    alu_vec("sltu", EXE_SLTU_OP, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b1);
    alu_vec("lui", EXE_LUI_OP, 32'd0, 32'h1234_5000, 32'h1234_5000, 1'b1);
    alu_vec("auipc", EXE_AUIPC_OP, 32'h1000, 32'h20, 32'h1020, 1'b1);
    alu_vec("jal", EXE_JAL_OP, 32'h1000, 32'h20, 32'h44, 1'b1);
    alu_vec("unknown", 6'h3F, 32'd7, 32'd9, 32'd0, 1'b0);
    aluop = EXE_ADD_OP; ignore = 1'b1; #1;
    check_val("ignore_data", wdata_out, 32'd0);
    check_val("ignore_wreg", {31'd0, wreg_out}, 32'd0);
    ignore = 1'b0;

    alu_vec("mul", EXE_MUL_OP, 32'hFFFF_FFFF, 32'd2, MEN ? 32'hFFFF_FFFE : 32'd0, MEN);
    alu_vec("mulh", EXE_MULH_OP, 32'hFFFF_FFFF, 32'd2, MEN ? 32'hFFFF_FFFF : 32'd0, MEN);
    alu_vec("mulhsu", EXE_MULHSU_OP, 32'hFFFF_FFFF, 32'd2, MEN ? 32'hFFFF_FFFF : 32'd0, MEN);
    alu_vec("mulhu", EXE_MULHU_OP, 32'hFFFF_FFFF, 32'd2, MEN ? 32'd1 : 32'd0, MEN);
    aluop = EXE_NOP_OP;

    // Divider timing and special results
    run_div("div", EXE_DIV_OP, 32'd100, 32'hFFFF_FFF9, MEN ? 33 : 0, MEN ? 32'hFFFF_FFF2 : 32'd0);
    run_div("rem", EXE_REM_OP, 32'd100, 32'hFFFF_FFF9, MEN ? 33 : 0, MEN ? 32'd2 : 32'd0);
    run_div("div_neg", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, MEN ? 33 : 0, MEN ? 32'hFFFF_FFFD : 32'd0);
    run_div("rem_neg", EXE_REM_OP, 32'hFFFF_FFF9, 32'd2, MEN ? 33 : 0, MEN ? 32'hFFFF_FFFF : 32'd0);
    run_div("divu_zero", EXE_DIVU_OP, 32'd5, 32'd0, MEN ? 1 : 0, MEN ? 32'hFFFF_FFFF : 32'd0);
    run_div("remu_zero", EXE_REMU_OP, 32'd9, 32'd0, MEN ? 1 : 0, MEN ? 32'd9 : 32'd0);
    run_div("div_ovf", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, MEN ? 1 : 0, MEN ? 32'h8000_0000 : 32'd0);
    run_div("rem_ovf", EXE_REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, MEN ? 1 : 0, 32'd0);

    // Abort in BUSY cycle 10
    @(posedge clk); #1;
    aluop = EXE_DIV_OP; reg1 = 32'd100; reg2 = 32'hFFFF_FFF9; wreg = 1'b1; ignore = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    ignore = 1'b1; #1;
    check_val("abort_stall", {31'd0, stallreq}, 32'd0);
    check_val("abort_wreg", {31'd0, wreg_out}, 32'd0);
    check_val("abort_data", wdata_out, 32'd0);
    run_div("abort_restart", EXE_DIVU_OP, 32'd7, 32'd2, MEN ? 33 : 0, MEN ? 32'd3 : 32'd0);

    // Reset in BUSY cycle 5
    @(posedge clk); #1;
    aluop = EXE_DIV_OP; reg1 = 32'd100; reg2 = 32'hFFFF_FFF9; wd = 5'd7; wreg = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0; #1;
    check_val("midrst_data", wdata_out, 32'd0);
    check_val("midrst_wreg", {31'd0, wreg_out}, 32'd0);
    check_val("midrst_wd", {27'd0, wd_out}, 32'd0);
    check_val("midrst_stall", {31'd0, stallreq}, 32'd0);
    @(posedge clk); #1;
    check_val("midrst_edge_stall", {31'd0, stallreq}, 32'd0);
    check_val("midrst_edge_data", wdata_out, 32'd0);
    aluop = EXE_NOP_OP; #1;
    rst = 1'b1;
    run_div("post_rst_divu", EXE_DIVU_OP, 32'd7, 32'd2, MEN ? 33 : 0, MEN ? 32'd3 : 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32I core. Sits directly downstream of the ID/EX pipeline register and consumes its outputs (aluop, two operands, destination register, write enable, stored PC, ignore flag). It computes the writeback value for the EX/MEM register. Single-cycle ALU operations complete combinationally; RV32M divide/remainder runs on an iterative divider that holds the pipeline through a stall request.

## Interface

Parameters:
- `DIV_CYCLES`, default 32: number of radix-2 iterations. Equals the operand width and is fixed for RV32.

Ports:
- `clk`, in, 1: core clock. Everything samples on the rising edge.
- `rst`, in, 1: reset. Synchronous and active-low: sampled on `posedge clk`, asserted when 0.
- `aluop_i`, in, 6: operation code from ID/EX. Encodings are in `defines.v`.
- `reg1_i`, in, 32: operand 1 (rs1, or PC for AUIPC/JAL).
- `reg2_i`, in, 32: operand 2 (rs2 or immediate).
- `wd_i`, in, 5: destination register address.
- `wreg_i`, in, 1: destination write enable.
- `pc_store_i`, in, 32: link address for JAL/JALR.
- `ignore_i`, in, 1: instruction is a squashed bubble.
- `wd_o`, out, 5: destination address to EX/MEM.
- `wreg_o`, out, 1: write enable to EX/MEM.
- `wdata_o`, out, 32: result.
- `stallreq_o`, out, 1: asks the pipeline controller to freeze PC, IF/ID and ID/EX.

## Operation

- Reset (`rst`==0): divider FSM goes to IDLE, internal operand, quotient and remainder registers clear, and every output is driven to 0.
- `ignore_i`==1 forces `wreg_o`=0, `wdata_o`=0 and `stallreq_o`=0. It never starts the divider.
- Single-cycle ops (ADD/SUB/logic/shifts/SLT/SLTU/LUI/AUIPC, JAL/JALR link, MUL/MULH/MULHSU/MULHU):
  - `wdata_o` is combinational from the inputs.
  - Shifts use only `reg2_i[4:0]`.
  - MULH* takes the upper 32 bits of the 64-bit product, signed/unsigned per the op.
  - JAL/JALR write `pc_store_i`.
  - Unknown op: `wdata_o`=0, `wreg_o`=0.
- `wd_o` always equals `wd_i`. `wreg_o` equals `wreg_i` except in the cases above.
- Div-class ops (DIV, DIVU, REM, REMU) use the divider FSM:
  - IDLE:
    - If a div-class op is present and not ignored, latch the absolute values of the operands and the result signs.
    - If the divisor is 0, or for signed overflow (`0x80000000` / `-1`), go to DONE. Otherwise go to BUSY with the iteration counter at 0.
  - BUSY: one shift-subtract step per cycle. After iteration `DIV_CYCLES-1`, go to DONE.
  - DONE: present the sign-corrected quotient or remainder on `wdata_o`, then return to IDLE next cycle.
- Special results:
  - Divide by zero: quotient=`0xFFFFFFFF`, remainder=dividend.
  - Signed overflow: quotient=`0x80000000`, remainder=0.
- `stallreq_o` = 1 whenever a non-ignored div-class op is present and the state is not DONE.
- Abort: `ignore_i` rising while in BUSY sends the FSM to IDLE next cycle and drops the stall the same cycle.
- Back-to-back divides: the DONE→IDLE transition coincides with ID/EX advancing, so IDLE sees the new op and starts it. No extra bubble is inserted.

## Timing

- Single-cycle ops: result valid in the same cycle, zero stall.
- Normal divide, with the op first seen at cycle 0:
  - IDLE at cycle 0, BUSY at cycles 1–32, DONE at cycle 33.
  - `stallreq_o` is high for cycles 0–32, i.e. 33 stall cycles.
  - `wdata_o` is valid at cycle 33.
- Divide-by-zero or overflow: DONE at cycle 1, one stall cycle.
- Reset mid-divide: FSM goes to IDLE at the next edge, and `stallreq_o`=0 while reset is asserted.
- Inputs are required stable while `stallreq_o`=1. The ID/EX register holds under stall.

## Configuration

- `RV32M_EN` defined:
  - The multiplier, the divider FSM and the `div_unit` instance are compiled in.
- `RV32M_EN` undefined:
  - MUL/DIV-class ops decode as unknown: `wdata_o`=0, `wreg_o`=0.
  - `stallreq_o` is tied to 0 and no divider logic exists.

## Structure

- `defines.v`:
  - Aluop codes, including `EXE_MUL_OP`…`EXE_REMU_OP`.
  - `RstEnable` (1'b0 for this block's reset polarity).
  - FSM state encodings `DivIdle`/`DivBusy`/`DivDone`.
  - `RegBus`/`RegAddrBus` widths.
- Sub-module `div_unit`:
  - Contains the FSM, the iteration counter and the quotient/remainder registers.
  - Start/abort inputs, result/ready outputs.
- The top level holds the ALU mux and the stall logic.

## Test plan

- ADD `reg1`=5, `reg2`=`0xFFFFFFFD`, `wd`=3 → same cycle `wdata_o`=2, `wreg_o`=1, `wd_o`=3, `stallreq_o`=0.
- DIV 100 / -7 → `stallreq_o` high for exactly 33 cycles; at cycle 33 `wdata_o`=`0xFFFFFFF2` (-14).
  - REM of the same operands → `wdata_o`=2.
- DIVU x / 0 → one stall cycle, `wdata_o`=`0xFFFFFFFF`.
  - REMU 9 / 0 → `wdata_o`=9.
- DIV `0x80000000` / `0xFFFFFFFF` → `wdata_o`=`0x80000000` after one stall cycle.
  - REM of the same operands → `wdata_o`=0.
- DIV started, then `ignore_i`=1 at BUSY cycle 10 → `stallreq_o`=0 that cycle, FSM back in IDLE next cycle, `wreg_o`=0.
- `rst`=0 asserted at BUSY cycle 5 → at the next edge all outputs are 0 and the state is IDLE.
  - A DIVU 7/2 issued after reset → `wdata_o`=3 at cycle 33.
